// File: rtl/ikaopll_bus_sched.sv
// rtl/ikaopll_bus_sched.sv - host write FIFO replayed into the OPLL register file on phi1 ticks
// Define IKAOPLL_BUSSCHED_DROPCNT_EN to add o_DROP_CNT, a saturating count of invalid-address drops.
module ikaopll_bus_sched #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_GAP   = 6,
  parameter int DATA_GAP   = 42
) (
  input  logic       i_EMUCLK,
  input  logic       i_RST,
  input  logic       i_phi1_NCEN_n,
  input  logic       i_CYCLE_00,
  input  logic       i_WR_VALID,
  output logic       o_WR_READY,
  input  logic       i_WR_A0,
  input  logic [7:0] i_WR_D,
  output logic       o_REG_WR_EN,
  output logic [5:0] o_REG_ADDR,
  output logic [7:0] o_REG_DATA,
  output logic       o_BUSY,
  output logic [4:0] o_FIFO_LVL
`ifdef IKAOPLL_BUSSCHED_DROPCNT_EN
  ,
  output logic [7:0] o_DROP_CNT
`endif
);

  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int GAP_MAX = (ADDR_GAP > DATA_GAP) ? ADDR_GAP : DATA_GAP;
  localparam int GW      = $clog2(GAP_MAX) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [8:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [4:0]    lvl_q, lvl_d;
  logic [7:0]    addr_q, addr_d;
  logic [7:0]    data_q, data_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          reg_wr_en_q, reg_wr_en_d;
  logic [5:0]    reg_addr_q, reg_addr_d;
  logic [7:0]    reg_data_q, reg_data_d;
  logic          tick;
  logic          push;
  logic          pop;
  logic [8:0]    head;

  assign tick       = ~i_phi1_NCEN_n;
  assign o_WR_READY = (lvl_q != 5'(FIFO_DEPTH));
  assign push       = i_WR_VALID & o_WR_READY;
  assign pop        = tick & (state_q == IDLE) & (lvl_q != 5'd0);
  assign head       = mem_q[rd_ptr_q];

  assign o_REG_WR_EN = reg_wr_en_q;
  assign o_REG_ADDR  = reg_addr_q;
  assign o_REG_DATA  = reg_data_q;
  assign o_BUSY      = (state_q != IDLE) | (lvl_q != 5'd0);
  assign o_FIFO_LVL  = lvl_q;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    lvl_d    = lvl_q + {4'd0, push} - {4'd0, pop};
  end

  // Entry bit 8 is A0: 0 selects the address latch, 1 a data write.
  always_ff @(posedge i_EMUCLK) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {i_WR_A0, i_WR_D};
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    gap_d       = gap_q;
    reg_wr_en_d = reg_wr_en_q;
    reg_addr_d  = reg_addr_q;
    reg_data_d  = reg_data_q;
    if (tick) begin
      reg_wr_en_d = 1'b0;
      case (state_q)
        IDLE: begin
          if (pop) begin
            if (head[8]) begin
              data_d  = head[7:0];
              state_d = SYNC;
            end else begin
              addr_d  = head[7:0];
              gap_d   = GW'(ADDR_GAP - 1);
              state_d = GAP;
            end
          end
        end
        SYNC: begin
          if (i_CYCLE_00) begin
            if (addr_q[7:6] == 2'b00) begin
              reg_wr_en_d = 1'b1;
              reg_addr_d  = addr_q[5:0];
              reg_data_d  = data_q;
            end
            gap_d   = GW'(DATA_GAP - 1);
            state_d = GAP;
          end
        end
        GAP: begin
          if (gap_q == '0) begin
            state_d = IDLE;
          end else begin
            gap_d = gap_q - GW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Address latch resets to 0xFF so data written before any address is dropped.
  always_ff @(posedge i_EMUCLK or posedge i_RST) begin
    if (i_RST) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      lvl_q       <= '0;
      addr_q      <= 8'hFF;
      data_q      <= '0;
      gap_q       <= '0;
      reg_wr_en_q <= 1'b0;
      reg_addr_q  <= '0;
      reg_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      lvl_q       <= lvl_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      gap_q       <= gap_d;
      reg_wr_en_q <= reg_wr_en_d;
      reg_addr_q  <= reg_addr_d;
      reg_data_q  <= reg_data_d;
    end
  end

`ifdef IKAOPLL_BUSSCHED_DROPCNT_EN
  logic       drop;
  logic [7:0] drop_cnt_q, drop_cnt_d;

  assign drop       = tick & (state_q == SYNC) & i_CYCLE_00 & (addr_q[7:6] != 2'b00);
  assign o_DROP_CNT = drop_cnt_q;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge i_EMUCLK or posedge i_RST) begin
    if (i_RST) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_ikaopll_bus_sched.sv
// tb/tb_ikaopll_bus_sched.sv - directed self-checking bench for ikaopll_bus_sched
module tb_ikaopll_bus_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ncen = 1'b1;
  logic       cyc0 = 1'b0;
  logic       wr_valid = 1'b0;
  logic       wr_a0 = 1'b0;
  logic [7:0] wr_d = 8'h00;
  logic       wr_ready;
  logic       reg_wr_en;
  logic [5:0] reg_addr;
  logic [7:0] reg_data;
  logic       busy;
  logic [4:0] fifo_lvl;
`ifdef IKAOPLL_BUSSCHED_DROPCNT_EN
  logic [7:0] drop_cnt;
`endif

  int tests = 0;
  int fails = 0;

  bit tick_en  = 1'b1;
  bit man_tick = 1'b0;
  bit ph       = 1'b0;
  int abs_tick = 0;

  int         pop_q[$];
  int         stb_tick_q[$];
  int         stb_c0_q[$];
  logic [5:0] stb_addr_q[$];
  logic [7:0] stb_data_q[$];
  int         fall_q[$];
  int         busy_fall_q[$];

  int cur;
  int lvl_prev  = 0;
  bit rdy_prev  = 1'b1;
  bit en_prev   = 1'b0;
  bit busy_prev = 1'b0;
  bit psh;

  ikaopll_bus_sched dut (
    .i_EMUCLK      (clk),
    .i_RST         (rst),
    .i_phi1_NCEN_n (ncen),
    .i_CYCLE_00    (cyc0),
    .i_WR_VALID    (wr_valid),
    .o_WR_READY    (wr_ready),
    .i_WR_A0       (wr_a0),
    .i_WR_D        (wr_d),
    .o_REG_WR_EN   (reg_wr_en),
    .o_REG_ADDR    (reg_addr),
    .o_REG_DATA    (reg_data),
    .o_BUSY        (busy),
    .o_FIFO_LVL    (fifo_lvl)
`ifdef IKAOPLL_BUSSCHED_DROPCNT_EN
    ,
    .o_DROP_CNT    (drop_cnt)
`endif
  );

  initial forever #5 clk = ~clk;

  // Tick every other clock; cycle 0 on every 18th tick, indexed by abs_tick.
  initial forever begin
    @(negedge clk);
    #1;
    if (tick_en) begin
      ph   = ~ph;
      ncen = ~ph;
      cyc0 = ph && (abs_tick % 18 == 0);
    end else begin
      ncen = ~man_tick;
      cyc0 = 1'b0;
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    cur = abs_tick;
    if (!ncen) abs_tick++;
    if (!rst) begin
      psh = wr_valid && rdy_prev;
      if (lvl_prev + int'(psh) - int'(fifo_lvl) == 1) pop_q.push_back(cur);
      if (!en_prev && reg_wr_en) begin
        stb_tick_q.push_back(cur);
        stb_c0_q.push_back(int'(cyc0));
        stb_addr_q.push_back(reg_addr);
        stb_data_q.push_back(reg_data);
      end
      if (en_prev && !reg_wr_en) fall_q.push_back(cur);
      if (busy_prev && !busy) busy_fall_q.push_back(cur);
    end
    lvl_prev  = int'(fifo_lvl);
    rdy_prev  = wr_ready;
    en_prev   = reg_wr_en;
    busy_prev = busy;
  end

  function automatic int next_c0(input int t);
    int v = t;
    while (v % 18 != 0) v++;
    return v;
  endfunction

  task automatic clear_logs;
    pop_q.delete();
    stb_tick_q.delete();
    stb_c0_q.delete();
    stb_addr_q.delete();
    stb_data_q.delete();
    fall_q.delete();
    busy_fall_q.delete();
  endtask

  task automatic do_reset;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    clear_logs();
  endtask

  task automatic push(input bit a0, input logic [7:0] d);
    bit acc = 1'b0;
    wr_valid = 1'b1;
    wr_a0    = a0;
    wr_d     = d;
    for (int i = 0; i < 400 && !acc; i++) begin
      acc = wr_ready;
      @(negedge clk);
    end
    wr_valid = 1'b0;
    tests++;
    if (!acc) begin
      fails++;
      $display("FAIL push_accept: byte %02h not accepted, got ready=0 want ready=1", d);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    tests++; if (reg_wr_en !== 1'b0) begin fails++; $display("FAIL reset_wr_en: got %0h want 0", reg_wr_en); end
    tests++; if (reg_addr !== 6'h00) begin fails++; $display("FAIL reset_addr: got %0h want 0", reg_addr); end
    tests++; if (reg_data !== 8'h00) begin fails++; $display("FAIL reset_data: got %0h want 0", reg_data); end
    tests++; if (wr_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %0h want 1", wr_ready); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %0h want 0", busy); end
    tests++; if (fifo_lvl !== 5'd0) begin fails++; $display("FAIL reset_lvl: got %0d want 0", fifo_lvl); end
    rst = 1'b0;
    clear_logs();
  endtask

  task automatic test_single_write;
    do_reset();
    push(1'b0, 8'h10);
    push(1'b1, 8'h55);
    for (int i = 0; i < 300 && stb_tick_q.size() < 1; i++) @(negedge clk);
    for (int i = 0; i < 300 && busy; i++) @(negedge clk);
    tests++;
    if (stb_tick_q.size() != 1) begin
      fails++;
      $display("FAIL single_count: got %0d strobes want 1", stb_tick_q.size());
    end
    if (stb_tick_q.size() >= 1 && pop_q.size() >= 2) begin
      tests++; if (stb_addr_q[0] !== 6'h10) begin fails++; $display("FAIL single_addr: got %0h want 10", stb_addr_q[0]); end
      tests++; if (stb_data_q[0] !== 8'h55) begin fails++; $display("FAIL single_data: got %0h want 55", stb_data_q[0]); end
      tests++; if (stb_c0_q[0] != 1) begin fails++; $display("FAIL single_cyc0: got %0d want 1", stb_c0_q[0]); end
      tests++; if (pop_q[1] - pop_q[0] != 7) begin fails++; $display("FAIL single_addr_gap: got %0d ticks want 7", pop_q[1] - pop_q[0]); end
      tests++; if (stb_tick_q[0] != next_c0(pop_q[1] + 1)) begin fails++; $display("FAIL single_strobe_tick: got %0d want %0d", stb_tick_q[0], next_c0(pop_q[1] + 1)); end
      tests++;
      if (fall_q.size() < 1 || fall_q[0] != stb_tick_q[0] + 1) begin
        fails++;
        $display("FAIL single_pulse_len: got fall count %0d want fall at tick %0d", fall_q.size(), stb_tick_q[0] + 1);
      end
    end
  endtask

  task automatic test_fifo_full;
    do_reset();
    tick_en = 1'b0;
    man_tick = 1'b0;
    @(negedge clk);
    @(negedge clk);
    for (int i = 1; i <= 4; i++) push(1'b0, 8'(i));
    tests++; if (fifo_lvl !== 5'd4) begin fails++; $display("FAIL full_lvl: got %0d want 4", fifo_lvl); end
    tests++; if (wr_ready !== 1'b0) begin fails++; $display("FAIL full_ready: got %0h want 0", wr_ready); end
    wr_valid = 1'b1;
    wr_a0    = 1'b0;
    wr_d     = 8'h05;
    repeat (5) @(negedge clk);
    tests++; if (fifo_lvl !== 5'd4) begin fails++; $display("FAIL full_hold_lvl: got %0d want 4", fifo_lvl); end
    tick_en = 1'b1;
    push(1'b0, 8'h05);
    tests++; if (pop_q.size() != 1) begin fails++; $display("FAIL full_5th_after_pop: got %0d pops want 1", pop_q.size()); end
    tests++; if (fifo_lvl !== 5'd4) begin fails++; $display("FAIL full_5th_lvl: got %0d want 4", fifo_lvl); end
    push(1'b0, 8'h06);
    tests++; if (pop_q.size() != 2) begin fails++; $display("FAIL full_6th_after_pop: got %0d pops want 2", pop_q.size()); end
  endtask

  task automatic test_repeat_data;
    do_reset();
    push(1'b0, 8'h30);
    push(1'b1, 8'h01);
    push(1'b1, 8'h02);
    for (int i = 0; i < 600 && stb_tick_q.size() < 2; i++) @(negedge clk);
    tests++;
    if (stb_tick_q.size() != 2) begin
      fails++;
      $display("FAIL repeat_count: got %0d strobes want 2", stb_tick_q.size());
    end
    if (stb_tick_q.size() >= 2 && pop_q.size() >= 3) begin
      tests++; if (stb_addr_q[0] !== 6'h30 || stb_addr_q[1] !== 6'h30) begin fails++; $display("FAIL repeat_addr: got %0h,%0h want 30,30", stb_addr_q[0], stb_addr_q[1]); end
      tests++; if (stb_data_q[0] !== 8'h01 || stb_data_q[1] !== 8'h02) begin fails++; $display("FAIL repeat_data: got %0h,%0h want 01,02", stb_data_q[0], stb_data_q[1]); end
      tests++; if (stb_c0_q[0] != 1 || stb_c0_q[1] != 1) begin fails++; $display("FAIL repeat_cyc0: got %0d,%0d want 1,1", stb_c0_q[0], stb_c0_q[1]); end
      tests++; if (pop_q[2] - stb_tick_q[0] != 43) begin fails++; $display("FAIL repeat_data_gap: got %0d ticks want 43", pop_q[2] - stb_tick_q[0]); end
      tests++; if (stb_tick_q[1] != next_c0(pop_q[2] + 1)) begin fails++; $display("FAIL repeat_second_tick: got %0d want %0d", stb_tick_q[1], next_c0(pop_q[2] + 1)); end
      tests++; if (stb_tick_q[1] - stb_tick_q[0] < 43) begin fails++; $display("FAIL repeat_spacing: got %0d ticks want >= 43", stb_tick_q[1] - stb_tick_q[0]); end
    end
  endtask

  task automatic test_invalid;
    do_reset();
    push(1'b0, 8'h45);
    push(1'b1, 8'hAA);
    for (int i = 0; i < 400 && busy_fall_q.size() < 1; i++) @(negedge clk);
    tests++; if (stb_tick_q.size() != 0) begin fails++; $display("FAIL invalid_no_strobe: got %0d strobes want 0", stb_tick_q.size()); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL invalid_idle: got busy=%0h want 0", busy); end
    tests++;
    if (busy_fall_q.size() < 1 || pop_q.size() < 2) begin
      fails++;
      $display("FAIL invalid_gap_end: got %0d busy falls want 1", busy_fall_q.size());
    end else if (busy_fall_q[0] != next_c0(pop_q[1] + 1) + 42) begin
      fails++;
      $display("FAIL invalid_gap_end: got tick %0d want %0d", busy_fall_q[0], next_c0(pop_q[1] + 1) + 42);
    end
`ifdef IKAOPLL_BUSSCHED_DROPCNT_EN
    tests++; if (drop_cnt !== 8'd1) begin fails++; $display("FAIL invalid_drop_cnt: got %0d want 1", drop_cnt); end
`endif
  endtask

  task automatic test_reset_mid;
    do_reset();
    push(1'b0, 8'h11);
    push(1'b1, 8'h22);
    for (int i = 0; i < 300 && !reg_wr_en; i++) @(negedge clk);
    tests++; if (reg_wr_en !== 1'b1) begin fails++; $display("FAIL mid_strobe_seen: got %0h want 1", reg_wr_en); end
    #2 rst = 1'b1;
    #1;
    tests++; if (reg_wr_en !== 1'b0) begin fails++; $display("FAIL mid_strobe_drop: got %0h want 0", reg_wr_en); end
    tests++; if (reg_addr !== 6'h00 || reg_data !== 8'h00) begin fails++; $display("FAIL mid_strobe_vals: got %0h/%0h want 0/0", reg_addr, reg_data); end
    @(negedge clk);
    rst = 1'b0;
    clear_logs();
    push(1'b0, 8'h20);
    push(1'b1, 8'h01);
    push(1'b1, 8'h02);
    push(1'b1, 8'h03);
    tests++; if (fifo_lvl !== 5'd3 || busy !== 1'b1) begin fails++; $display("FAIL mid_gap_setup: got lvl %0d busy %0h want 3 1", fifo_lvl, busy); end
    #2 rst = 1'b1;
    #1;
    tests++; if (fifo_lvl !== 5'd0 || wr_ready !== 1'b1) begin fails++; $display("FAIL mid_async_fifo: got lvl %0d ready %0h want 0 1", fifo_lvl, wr_ready); end
    tests++; if (busy !== 1'b0 || reg_wr_en !== 1'b0) begin fails++; $display("FAIL mid_async_busy: got busy %0h en %0h want 0 0", busy, reg_wr_en); end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (busy !== 1'b0 || fifo_lvl !== 5'd0) begin fails++; $display("FAIL mid_after_release: got busy %0h lvl %0d want 0 0", busy, fifo_lvl); end
    clear_logs();
  endtask

  task automatic test_back_to_back;
    do_reset();
    tick_en = 1'b0;
    man_tick = 1'b0;
    @(negedge clk);
    @(negedge clk);
    push(1'b0, 8'h01);
    push(1'b0, 8'h02);
    tests++; if (fifo_lvl !== 5'd2) begin fails++; $display("FAIL b2b_setup: got %0d want 2", fifo_lvl); end
    for (int r = 0; r < 3; r++) begin
      man_tick = 1'b1;
      wr_valid = 1'b1;
      wr_a0    = 1'b0;
      wr_d     = 8'h10 + 8'(r);
      @(negedge clk);
      man_tick = 1'b0;
      wr_valid = 1'b0;
      tests++; if (fifo_lvl !== 5'd2) begin fails++; $display("FAIL b2b_push_pop_%0d: got %0d want 2", r, fifo_lvl); end
      repeat (6) begin
        man_tick = 1'b1;
        @(negedge clk);
        man_tick = 1'b0;
        @(negedge clk);
      end
      tests++; if (fifo_lvl !== 5'd2) begin fails++; $display("FAIL b2b_gap_hold_%0d: got %0d want 2", r, fifo_lvl); end
    end
    tests++; if (pop_q.size() != 3) begin fails++; $display("FAIL b2b_pops: got %0d want 3", pop_q.size()); end
    tick_en = 1'b1;
    do_reset();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_fifo_full();
    test_repeat_data();
    test_invalid();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
